siso: RTL and testbench

- Serial-in, serial-out shift register. Each rising clock edge captures one bit on din, and the bit captured WIDTH edges earlier appears on dout.
- Used as a fixed-length bit delay line and serial pipeline stage in the sequential-circuits library.
- Internal state is a single WIDTH-bit register named shift_reg. Benches probe it hierarchically as uut.shift_reg, so the name is part of the contract.

---
 rtl/siso_pkg.sv | 13 +
 rtl/siso_stage.sv | 23 ++
 rtl/siso.sv | 55 +++++
 tb/tb_siso.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/siso_pkg.sv
// Shared definitions for the serial shift-register family (SISO/SIPO/PISO/PIPO).
//   SISO_DEFAULT_WIDTH : default stage count for siso
//   shift_dir_e        : shift direction, SHIFT_RIGHT toward the LSB, SHIFT_LEFT toward the MSB
package siso_pkg;

    localparam int SISO_DEFAULT_WIDTH = 4;

    typedef enum logic {
        SHIFT_RIGHT = 1'b0,
        SHIFT_LEFT  = 1'b1
    } shift_dir_e;

endpackage

// File: rtl/siso_stage.sv
// One bit of the siso shift register: a D flop with asynchronous active-low reset.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset, loads RESET_VALUE
//   d   : next bit
//   q   : stored bit
module siso_stage #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= RESET_VALUE;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/siso.sv
// Serial-in serial-out shift register: a WIDTH-cycle bit delay line.
//   clk  : rising-edge clock, shifts on every edge (no enable)
//   rst  : asynchronous active-low reset, loads shift_reg with RESET_VALUE
//   din  : serial input, enters the input end of shift_reg
//   dout : serial output, taken combinationally from the output end of shift_reg
// SHIFT_LEFT=1 shifts toward the MSB (din -> bit 0, dout <- bit WIDTH-1);
// SHIFT_LEFT=0 shifts toward the LSB (din -> bit WIDTH-1, dout <- bit 0).
module siso #(
    parameter int               WIDTH       = siso_pkg::SISO_DEFAULT_WIDTH,
    parameter bit               SHIFT_LEFT  = 1'b1,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    import siso_pkg::*;

    // The local parameter SHIFT_LEFT shadows the package enumerator of the same name,
    // so the enumerator is always referenced with its package prefix.
    localparam shift_dir_e Dir = SHIFT_LEFT ? siso_pkg::SHIFT_LEFT : SHIFT_RIGHT;

    // Probed hierarchically by benches; the name is part of the block's interface.
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_next;

    if (WIDTH < 1) begin : g_width_check
        $error("siso: WIDTH must be at least 1 (got %0d)", WIDTH);
    end

    if (WIDTH == 1) begin : g_single
        assign shift_next = din;
        assign dout       = shift_reg[0];
    end else if (Dir == siso_pkg::SHIFT_LEFT) begin : g_left
        assign shift_next = {shift_reg[WIDTH-2:0], din};
        assign dout       = shift_reg[WIDTH-1];
    end else begin : g_right
        assign shift_next = {din, shift_reg[WIDTH-1:1]};
        assign dout       = shift_reg[0];
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        siso_stage #(
            .RESET_VALUE(RESET_VALUE[i])
        ) u_stage (
            .clk(clk),
            .rst(rst),
            .d  (shift_next[i]),
            .q  (shift_reg[i])
        );
    end

endmodule

// File: tb/tb_siso.sv
// Self-checking bench for siso. Four instances share clk/rst/din:
//   uut    WIDTH=4 left,  reset 0
//   uut_r  WIDTH=4 right, reset 0
//   uut_1  WIDTH=1 right, reset 0
//   uut_8  WIDTH=8 left,  reset 8'hA5
// The model keeps the history of bits sampled since the last reset and derives each
// instance's register contents from bit ages.
module tb_siso;

    logic clk;
    logic rst;
    logic din;
    logic dout, dout_r, dout_1, dout_8;

    int checks = 0;
    int errors = 0;

    // hist[0] is the most recently sampled bit.
    bit hist[$];

    siso #(.WIDTH(4), .SHIFT_LEFT(1'b1), .RESET_VALUE(4'b0000)) uut (
        .clk(clk), .rst(rst), .din(din), .dout(dout)
    );
    siso #(.WIDTH(4), .SHIFT_LEFT(1'b0), .RESET_VALUE(4'b0000)) uut_r (
        .clk(clk), .rst(rst), .din(din), .dout(dout_r)
    );
    siso #(.WIDTH(1), .SHIFT_LEFT(1'b0), .RESET_VALUE(1'b0)) uut_1 (
        .clk(clk), .rst(rst), .din(din), .dout(dout_1)
    );
    siso #(.WIDTH(8), .SHIFT_LEFT(1'b1), .RESET_VALUE(8'hA5)) uut_8 (
        .clk(clk), .rst(rst), .din(din), .dout(dout_8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model update: one sample per edge while out of reset; reset discards the history.
    always @(posedge clk) begin
        if (rst === 1'b1) begin
            hist.push_front(din);
            if (hist.size() > 64) void'(hist.pop_back());
        end
    end
    always @(negedge rst) hist.delete();

    // Bit j's content comes from its age: the sample taken that many edges ago, or a
    // reset bit displaced by the number of shifts performed so far.
    function automatic logic [63:0] exp_reg(input int w, input bit left, input logic [63:0] rv);
        logic [63:0] r;
        int n;
        int k;
        r = '0;
        n = hist.size();
        for (int j = 0; j < w; j++) begin
            k = left ? j : (w - 1 - j);
            if (k < n) r[j] = hist[k];
            else       r[j] = left ? rv[j - n] : rv[j + n];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_inst(input string name, input int w, input bit left,
                              input logic [63:0] rv, input logic [63:0] act_reg,
                              input logic act_dout);
        logic [63:0] e;
        e = exp_reg(w, left, rv);
        check({name, ".shift_reg"}, act_reg, e);
        check({name, ".dout"}, {63'b0, act_dout}, {63'b0, left ? e[w-1] : e[0]});
    endtask

    // Model compare on every sampling point, away from the active edge.
    always @(negedge clk) begin
        check_inst("uut",   4, 1'b1, 64'h0,  {60'b0, uut.shift_reg},   dout);
        check_inst("uut_r", 4, 1'b0, 64'h0,  {60'b0, uut_r.shift_reg}, dout_r);
        check_inst("uut_1", 1, 1'b0, 64'h0,  {63'b0, uut_1.shift_reg}, dout_1);
        check_inst("uut_8", 8, 1'b1, 64'hA5, {56'b0, uut_8.shift_reg}, dout_8);
    end

    // Drive din then wait for the next sampling point (one edge later).
    task automatic step(input logic b);
        din = b;
        @(negedge clk);
    endtask

    logic [3:0] pat;
    logic [3:0] exp_l [4];
    logic [3:0] exp_r [4];
    logic [3:0] drain_dout;

    initial begin
        pat        = 4'b1101;  // din order 1,0,1,1 from bit 0 upward
        exp_l      = '{4'b0001, 4'b0010, 4'b0101, 4'b1011};
        exp_r      = '{4'b1000, 4'b0100, 4'b1010, 4'b1101};
        drain_dout = 4'b0110;  // dout after drain edges 1..4: 0,1,1,0 (bit 0 first)

        rst = 1'b1;
        din = 1'b1;
        #1 rst = 1'b0;

        // Reset held with din=1 and clock running.
        repeat (2) begin
            @(negedge clk);
            check("reset.shift_reg", {60'b0, uut.shift_reg}, 64'h0);
            check("reset.dout", {63'b0, dout}, 64'h0);
            check("reset.uut_8", {56'b0, uut_8.shift_reg}, 64'hA5);
        end
        #2 rst = 1'b1;  // release at 22 ns, mid-cycle

        for (int i = 0; i < 4; i++) begin
            step(pat[i]);
            check("pattern.left", {60'b0, uut.shift_reg}, {60'b0, exp_l[i]});
            check("pattern.right", {60'b0, uut_r.shift_reg}, {60'b0, exp_r[i]});
            check("pattern.w1", {63'b0, dout_1}, {63'b0, pat[i]});
        end
        check("pattern.dout4", {63'b0, dout}, 64'h1);

        for (int i = 0; i < 4; i++) begin
            step(1'b0);
            check("drain.dout", {63'b0, dout}, {63'b0, drain_dout[i]});
        end
        check("drain.final", {60'b0, uut.shift_reg}, 64'h0);

        // Reload 1011, then assert reset between edges.
        for (int i = 0; i < 4; i++) step(pat[i]);
        check("reload", {60'b0, uut.shift_reg}, 64'hB);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("async.shift_reg", {60'b0, uut.shift_reg}, 64'h0);
        check("async.dout", {63'b0, dout}, 64'h0);
        check("async.uut_8", {56'b0, uut_8.shift_reg}, 64'hA5);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        step(1'b1);
        check("post_reset.left", {60'b0, uut.shift_reg}, 64'h1);
        check("post_reset.right", {60'b0, uut_r.shift_reg}, 64'h8);
        step(1'b1);
        check("post_reset.left2", {60'b0, uut.shift_reg}, 64'h3);

        // Random soak; the compare process checks every cycle.
        for (int i = 0; i < 1000; i++) step(1'($urandom_range(0, 1)));

        // Short reset pulse mid-soak then more traffic.
        #2 rst = 1'b0;
        #2 rst = 1'b1;
        for (int i = 0; i < 200; i++) step(1'($urandom_range(0, 1)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
